// File: rtl/dsi_video_timing_monitor.sv
// rtl/dsi_video_timing_monitor.sv - DSI bridge video passthrough with geometry measurement and lock detection
// Optional VTM_ERR_STICKY_EN: error flags hold until clr_err_i instead of pulsing for one cycle.
module dsi_video_timing_monitor #(
  parameter int PD_WIDTH     = 24,
  parameter int CNT_WIDTH    = 12,
  parameter int EXP_H_ACTIVE = 1280,
  parameter int EXP_V_ACTIVE = 1024,
  parameter int LOCK_FRAMES  = 3
) (
  input  logic                 clk_pixel_i,
  input  logic                 reset_n_i,
  input  logic [PD_WIDTH-1:0]  pd_i,
  input  logic                 vsync_i,
  input  logic                 hsync_i,
  input  logic                 de_i,
  input  logic                 clr_err_i,
  output logic [PD_WIDTH-1:0]  pd_o,
  output logic                 vsync_o,
  output logic                 hsync_o,
  output logic                 de_o,
  output logic [CNT_WIDTH-1:0] h_active_o,
  output logic [CNT_WIDTH-1:0] v_active_o,
  output logic [15:0]          frame_cnt_o,
  output logic                 locked_o,
  output logic                 err_h_o,
  output logic                 err_v_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] EXP_H   = CNT_WIDTH'(EXP_H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] EXP_V   = CNT_WIDTH'(EXP_V_ACTIVE);
  localparam logic [3:0]           LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_CHECK,
    ST_LOCKED
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           good_cnt_q, good_cnt_d;
  logic [PD_WIDTH-1:0]  pd_q;
  logic                 vsync_q, hsync_q, de_q;
  logic [CNT_WIDTH-1:0] pix_cnt_q, line_cnt_q, h_active_q, v_active_q;
  logic                 line_bad_q;
  logic [15:0]          frame_cnt_q;
  logic                 err_h_q, err_h_d, err_v_q, err_v_d;

  logic                 vs_r, de_f, measuring, line_end, judge;
  logic                 h_mis, v_mis, frame_good, line_bad_end;
  logic [CNT_WIDTH-1:0] line_cnt_inc, line_cnt_end;

  assign vs_r      = vsync_i & ~vsync_q;
  assign de_f      = de_q & ~de_i;
  assign measuring = (state_q != ST_SEARCH);
  assign line_end  = measuring & de_f;
  assign judge     = measuring & vs_r;

  assign line_cnt_inc = (line_cnt_q == CNT_MAX) ? line_cnt_q : line_cnt_q + CNT_ONE;
  assign h_mis        = line_end & ((pix_cnt_q != EXP_H) | (pix_cnt_q == CNT_MAX));

  // A line can close on the same edge vsync rises; fold it into the finishing frame.
  assign line_cnt_end = line_end ? line_cnt_inc : line_cnt_q;
  assign line_bad_end = line_bad_q | h_mis;
  assign v_mis        = judge & (line_cnt_end != EXP_V);
  assign frame_good   = ~line_bad_end & (line_cnt_end == EXP_V) & ~de_i;

  always_ff @(posedge clk_pixel_i) begin
    if (!reset_n_i) begin
      pd_q        <= '0;
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      de_q        <= 1'b0;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      line_bad_q  <= 1'b0;
      h_active_q  <= '0;
      v_active_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      pd_q    <= pd_i;
      vsync_q <= vsync_i;
      hsync_q <= hsync_i;
      de_q    <= de_i;

      if (vs_r || !measuring) begin
        pix_cnt_q  <= '0;
        line_cnt_q <= '0;
        line_bad_q <= 1'b0;
      end else begin
        if (de_f) begin
          pix_cnt_q  <= '0;
          line_cnt_q <= line_cnt_inc;
        end else if (de_i && (pix_cnt_q != CNT_MAX)) begin
          pix_cnt_q <= pix_cnt_q + CNT_ONE;
        end
        if (h_mis) begin
          line_bad_q <= 1'b1;
        end
      end

      if (line_end) begin
        h_active_q <= pix_cnt_q;
      end
      if (judge) begin
        v_active_q <= line_cnt_end;
      end
      if (vs_r) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

`ifdef VTM_ERR_STICKY_EN
  always_comb begin
    err_h_d = h_mis | (err_h_q & ~clr_err_i);
    err_v_d = v_mis | (err_v_q & ~clr_err_i);
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err_i;

  always_comb begin
    err_h_d = h_mis;
    err_v_d = v_mis;
  end
`endif

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    if (vs_r) begin
      case (state_q)
        ST_SEARCH: begin
          state_d    = ST_MEASURE;
          good_cnt_d = 4'd0;
        end
        ST_MEASURE: begin
          if (frame_good) begin
            good_cnt_d = 4'd1;
            state_d    = (LOCK_N == 4'd1) ? ST_LOCKED : ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_d == LOCK_N) begin
              state_d = ST_LOCKED;
            end
          end else begin
            state_d    = ST_MEASURE;
            good_cnt_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (!frame_good) begin
            state_d    = ST_MEASURE;
            good_cnt_d = 4'd0;
          end
        end
        default: begin
          state_d    = ST_SEARCH;
          good_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pixel_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_SEARCH;
      good_cnt_q <= 4'd0;
      err_h_q    <= 1'b0;
      err_v_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      err_h_q    <= err_h_d;
      err_v_q    <= err_v_d;
    end
  end

  assign pd_o        = pd_q;
  assign vsync_o     = vsync_q;
  assign hsync_o     = hsync_q;
  assign de_o        = de_q;
  assign h_active_o  = h_active_q;
  assign v_active_o  = v_active_q;
  assign frame_cnt_o = frame_cnt_q;
  assign locked_o    = (state_q == ST_LOCKED);
  assign err_h_o     = err_h_q;
  assign err_v_o     = err_v_q;

endmodule

// File: tb/tb_dsi_video_timing_monitor.sv
// tb/tb_dsi_video_timing_monitor.sv - randomized frame-level bench for dsi_video_timing_monitor
// Shrunk geometry keeps frames short; a frame-level model predicts geometry, errors and lock.
module tb_dsi_video_timing_monitor;

  localparam int PDW = 24;
  localparam int CW  = 12;
  localparam int EH  = 16;
  localparam int EV  = 6;
  localparam int LF  = 3;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
`ifdef VTM_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n_i = 1'b0;
  logic [PDW-1:0] pd_i = '0;
  logic           vsync_i = 1'b0, hsync_i = 1'b0, de_i = 1'b0, clr_err_i = 1'b0;
  logic [PDW-1:0] pd_o;
  logic           vsync_o, hsync_o, de_o;
  logic [CW-1:0]  h_active_o, v_active_o;
  logic [15:0]    frame_cnt_o;
  logic           locked_o, err_h_o, err_v_o;

  int checks = 0;
  int errors = 0;

  logic [15:0]   m_frame_cnt;
  bit            m_synced, m_bad, m_eh, m_ev;
  int            m_consec;
  logic [CW-1:0] m_lines;

  dsi_video_timing_monitor #(
    .PD_WIDTH(PDW), .CNT_WIDTH(CW), .EXP_H_ACTIVE(EH), .EXP_V_ACTIVE(EV), .LOCK_FRAMES(LF)
  ) dut (
    .clk_pixel_i(clk), .reset_n_i(reset_n_i), .pd_i(pd_i), .vsync_i(vsync_i),
    .hsync_i(hsync_i), .de_i(de_i), .clr_err_i(clr_err_i), .pd_o(pd_o),
    .vsync_o(vsync_o), .hsync_o(hsync_o), .de_o(de_o), .h_active_o(h_active_o),
    .v_active_o(v_active_o), .frame_cnt_o(frame_cnt_o), .locked_o(locked_o),
    .err_h_o(err_h_o), .err_v_o(err_v_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_locked();
    return m_consec >= LF;
  endfunction

  task automatic model_reset();
    m_frame_cnt = '0;
    m_synced    = 1'b0;
    m_bad       = 1'b0;
    m_eh        = 1'b0;
    m_ev        = 1'b0;
    m_consec    = 0;
    m_lines     = '0;
  endtask

  task automatic send_line(input int w);
    logic [CW-1:0] exp_h;
    bit            mis;
    hsync_i = 1'b1; cyc();
    hsync_i = 1'b0; cyc();
    de_i = 1'b1;
    repeat (w) begin
      pd_i = PDW'($urandom);
      cyc();
    end
    de_i = 1'b0;
    cyc();
    if (m_synced) begin
      exp_h = (w > int'(CMAX)) ? CMAX : CW'(w);
      mis   = (w >= int'(CMAX)) || (w != EH);
      if (m_lines != CMAX) m_lines = m_lines + CW'(1);
      m_bad = m_bad | mis;
      m_eh  = STICKY ? (m_eh | mis) : mis;
      checks++;
      if (h_active_o !== exp_h) begin
        errors++;
        $display("FAIL line_h_active: got %0d expected %0d", h_active_o, exp_h);
      end
      checks++;
      if (err_h_o !== m_eh) begin
        errors++;
        $display("FAIL line_err_h: got %0b expected %0b (width %0d)", err_h_o, m_eh, w);
      end
    end
    cyc(); cyc();
    if (!STICKY) m_eh = 1'b0;
  endtask

  // Closes the current frame with a vsync rise; with_de leaves de_i high across the rise.
  task automatic send_vsync(input bit with_de, input bit clr);
    bit vmis, good;
    checks++;
    if (locked_o !== m_locked()) begin
      errors++;
      $display("FAIL locked_before_vsync: got %0b expected %0b", locked_o, m_locked());
    end
    vsync_i   = 1'b1;
    clr_err_i = clr;
    cyc();
    clr_err_i = 1'b0;
    m_frame_cnt = m_frame_cnt + 16'd1;
    if (STICKY && clr) m_eh = 1'b0;
    if (m_synced) begin
      vmis = (m_lines != CW'(EV));
      good = !m_bad && !vmis && !with_de;
      m_ev = STICKY ? (((clr ? 1'b0 : m_ev)) | vmis) : vmis;
      checks++;
      if (v_active_o !== m_lines) begin
        errors++;
        $display("FAIL frame_v_active: got %0d expected %0d", v_active_o, m_lines);
      end
      checks++;
      if (err_v_o !== m_ev) begin
        errors++;
        $display("FAIL frame_err_v: got %0b expected %0b", err_v_o, m_ev);
      end
      m_consec = good ? m_consec + 1 : 0;
    end else begin
      m_synced = 1'b1;
      m_consec = 0;
      if (STICKY && clr) m_ev = 1'b0;
    end
    m_lines = '0;
    m_bad   = 1'b0;
    checks++;
    if (frame_cnt_o !== m_frame_cnt) begin
      errors++;
      $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt_o, m_frame_cnt);
    end
    checks++;
    if (locked_o !== m_locked()) begin
      errors++;
      $display("FAIL locked_after_vsync: got %0b expected %0b", locked_o, m_locked());
    end
    checks++;
    if (err_h_o !== m_eh) begin
      errors++;
      $display("FAIL vsync_err_h: got %0b expected %0b", err_h_o, m_eh);
    end
    if (!with_de) begin
      cyc(); cyc();
      vsync_i = 1'b0;
      cyc(); cyc();
      if (!STICKY) m_ev = 1'b0;
    end
  endtask

  task automatic send_frame(input int nl, input int bad_idx, input int bad_w);
    for (int i = 0; i < nl; i++) send_line((i == bad_idx) ? bad_w : EH);
    send_vsync(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [PDW-1:0] pd_prev;
    logic           hs_prev, de_prev;
    reset_n_i = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      pd_i = PDW'($urandom); vsync_i = 1'($urandom); hsync_i = 1'($urandom);
      de_i = 1'($urandom); clr_err_i = 1'($urandom);
      cyc();
      checks++;
      if ({pd_o, vsync_o, hsync_o, de_o, h_active_o, v_active_o, frame_cnt_o,
           locked_o, err_h_o, err_v_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: cycle %0d pd_o=%h fc=%0d locked=%0b", i, pd_o, frame_cnt_o, locked_o);
      end
    end
    vsync_i = 1'b0; clr_err_i = 1'b0; de_i = 1'b0; hsync_i = 1'b0;
    reset_n_i = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      pd_i = PDW'($urandom); hsync_i = 1'($urandom); de_i = 1'($urandom);
      pd_prev = pd_i; hs_prev = hsync_i; de_prev = de_i;
      cyc();
      pd_i = PDW'($urandom); hsync_i = ~hs_prev; de_i = ~de_prev;
      #1;
      checks++;
      if ({pd_o, hsync_o, de_o, vsync_o} !== {pd_prev, hs_prev, de_prev, 1'b0}) begin
        errors++;
        $display("FAIL passthrough: got pd=%h hs=%0b de=%0b expected pd=%h hs=%0b de=%0b",
                 pd_o, hsync_o, de_o, pd_prev, hs_prev, de_prev);
      end
    end
    de_i = 1'b0; hsync_i = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_lock();
    send_vsync(1'b0, 1'b0);
    repeat (3) send_frame(EV, -1, 0);
    checks++;
    if ({frame_cnt_o, h_active_o, v_active_o, locked_o} !==
        {16'd4, CW'(EH), CW'(EV), 1'b1}) begin
      errors++;
      $display("FAIL lock_summary: got fc=%0d h=%0d v=%0d locked=%0b expected 4 %0d %0d 1",
               frame_cnt_o, h_active_o, v_active_o, locked_o, EH, EV);
    end
  endtask

  task automatic test_width_err();
    send_frame(EV, 2, EH - 1);
    checks++;
    if (locked_o !== 1'b0) begin
      errors++;
      $display("FAIL width_err_unlock: got %0b expected 0", locked_o);
    end
    repeat (3) send_frame(EV, -1, 0);
    checks++;
    if (locked_o !== 1'b1) begin
      errors++;
      $display("FAIL width_err_relock: got %0b expected 1", locked_o);
    end
  endtask

  task automatic test_height_err();
    for (int i = 0; i < EV - 1; i++) send_line(EH);
    send_vsync(1'b0, 1'b1);
    checks++;
    if ({v_active_o, locked_o} !== {CW'(EV - 1), 1'b0}) begin
      errors++;
      $display("FAIL height_err: got v=%0d locked=%0b expected v=%0d locked=0", v_active_o, locked_o, EV - 1);
    end
    checks++;
    if (err_v_o !== STICKY) begin
      errors++;
      $display("FAIL height_err_hold: got %0b expected %0b", err_v_o, STICKY);
    end
    clr_err_i = 1'b1; cyc(); clr_err_i = 1'b0;
    m_eh = 1'b0; m_ev = 1'b0;
    checks++;
    if ({err_h_o, err_v_o} !== 2'b00) begin
      errors++;
      $display("FAIL clear_errors: got %b expected 00", {err_h_o, err_v_o});
    end
  endtask

  task automatic test_saturation();
    send_line(4100);
    checks++;
    if (h_active_o !== CMAX) begin
      errors++;
      $display("FAIL saturation_h_active: got %0d expected %0d", h_active_o, CMAX);
    end
    for (int i = 0; i < EV - 1; i++) send_line(EH);
    send_vsync(1'b0, 1'b0);
  endtask

  task automatic test_random();
    int nl;
    for (int f = 0; f < 6; f++) begin
      nl = EV;
      if ($urandom_range(4) == 0) nl = $urandom_range(1) ? EV + 1 : EV - 1;
      for (int i = 0; i < nl; i++)
        send_line(($urandom_range(5) == 0) ? int'($urandom_range(EH + 3, 1)) : EH);
      send_vsync(1'b0, 1'b0);
    end
  endtask

  task automatic test_vs_in_de();
    repeat (4) send_frame(EV, -1, 0);
    for (int i = 0; i < EV; i++) send_line(EH);
    hsync_i = 1'b1; cyc(); hsync_i = 1'b0; cyc();
    de_i = 1'b1;
    repeat (5) cyc();
    send_vsync(1'b1, 1'b0);
    checks++;
    if (locked_o !== 1'b0) begin
      errors++;
      $display("FAIL vs_in_de_unlock: got %0b expected 0", locked_o);
    end
  endtask

  task automatic test_midframe_reset();
    vsync_i = 1'b0;
    repeat (3) cyc();
    reset_n_i = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({locked_o, frame_cnt_o, h_active_o, v_active_o, err_h_o, err_v_o} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got locked=%0b fc=%0d h=%0d v=%0d", locked_o, frame_cnt_o, h_active_o, v_active_o);
    end
    de_i = 1'b0;
    reset_n_i = 1'b1;
    model_reset();
    cyc();
    send_line(EH - 5);
    send_line(EH - 5);
    send_vsync(1'b0, 1'b0);
    checks++;
    if ({h_active_o, v_active_o, err_h_o, err_v_o, locked_o} !== '0) begin
      errors++;
      $display("FAIL search_not_judged: got h=%0d v=%0d eh=%0b ev=%0b locked=%0b",
               h_active_o, v_active_o, err_h_o, err_v_o, locked_o);
    end
    repeat (3) send_frame(EV, -1, 0);
    checks++;
    if ({locked_o, frame_cnt_o} !== {1'b1, 16'd4}) begin
      errors++;
      $display("FAIL relock_after_reset: got locked=%0b fc=%0d expected 1 4", locked_o, frame_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_width_err();
    test_height_err();
    test_saturation();
    test_random();
    test_vs_in_de();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
